// File: rtl/rbus_arbiter_pkg.sv
// rbus_arbiter_pkg: shared state encodings and bus-width defaults for the rbus arbiter.
// Revision 1.0
`default_nettype none

package rbus_arbiter_pkg;

  localparam int MEM_BUS_W = 32;
  localparam int REG_BUS_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // A one-deep burst still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rbus_arbiter.sv
// rbus_arbiter: registered-grant round-robin arbiter for two rbus masters with burst cap and lock.
// Revision 1.0
`default_nettype none

module rbus_arbiter
  import rbus_arbiter_pkg::*;
#(
  parameter int AW        = MEM_BUS_W,
  parameter int DW        = REG_BUS_W,
  parameter int MAX_BURST = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  output logic          m0_gnt_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic          bus_we_o,
  input  logic [DW-1:0] bus_rdata_i
);

  localparam int            CW      = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  arb_state_e    state, state_nxt;
  logic          rr_last, rr_last_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;

  logic       owner1;
  logic       own_req;
  logic       own_lock;
  logic       other_req;
  arb_state_e other_state;

  // Owner-relative views so both OWN states share one set of leave rules.
  assign owner1      = (state == ARB_OWN1);
  assign own_req     = owner1 ? m1_req_i  : m0_req_i;
  assign own_lock    = owner1 ? m1_lock_i : m0_lock_i;
  assign other_req   = owner1 ? m0_req_i  : m1_req_i;
  assign other_state = owner1 ? ARB_OWN0  : ARB_OWN1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ARB_IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    burst_cnt_nxt = burst_cnt;
    case (state)
      ARB_IDLE: begin
        burst_cnt_nxt = '0;
        if (m0_req_i && m1_req_i) begin
          state_nxt = rr_last ? ARB_OWN0 : ARB_OWN1;
        end else if (m0_req_i) begin
          state_nxt = ARB_OWN0;
        end else if (m1_req_i) begin
          state_nxt = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!own_req) begin
          state_nxt     = other_req ? other_state : ARB_IDLE;
          rr_last_nxt   = owner1;
          burst_cnt_nxt = '0;
        end else if ((burst_cnt == CNT_MAX) && other_req && !own_lock) begin
          state_nxt     = other_state;
          rr_last_nxt   = owner1;
          burst_cnt_nxt = '0;
        end else if (burst_cnt != CNT_MAX) begin
          // Saturates under lock so the cap fires as soon as the lock drops.
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = ARB_IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_we_o    = 1'b0;
    case (state)
      ARB_OWN0: begin
        m0_gnt_o    = 1'b1;
        bus_addr_o  = m0_addr_i;
        bus_wdata_o = m0_wdata_i;
        bus_we_o    = m0_we_i & m0_req_i;
        m0_rdata_o  = m0_req_i ? bus_rdata_i : '0;
      end
      ARB_OWN1: begin
        m1_gnt_o    = 1'b1;
        bus_addr_o  = m1_addr_i;
        bus_wdata_o = m1_wdata_i;
        bus_we_o    = m1_we_i & m1_req_i;
        m1_rdata_o  = m1_req_i ? bus_rdata_i : '0;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_rbus_arbiter.sv
// tb_rbus_arbiter: directed self-checking bench for rbus_arbiter (MAX_BURST=8).
// Revision 1.0
`default_nettype none

module tb_rbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req, m0_we, m0_lock, m0_gnt;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          bus_we;

  int tests = 0;
  int fails = 0;

  rbus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_we_i(m0_we),
    .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_i(m1_we),
    .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_we_o(bus_we),
    .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    m0_req = 1; m1_req = 1; m0_we = 1; m0_addr = 32'h44;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt, bus_we} !== 3'b000 || bus_addr !== '0 || bus_wdata !== '0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      fails++;
      $display("FAIL reset_outputs: gnt1=%b gnt0=%b we=%b addr=%h wdata=%h rd0=%h rd1=%h, want all 0",
               m1_gnt, m0_gnt, bus_we, bus_addr, bus_wdata, m0_rdata, m1_rdata);
    end
    do_reset();
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt, bus_we} !== 3'b000 || bus_addr !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: gnt1=%b gnt0=%b we=%b addr=%h, want 0", m1_gnt, m0_gnt, bus_we, bus_addr);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h100; m0_we = 0; bus_rdata = 32'hCAFE_0001;
    @(negedge clk);
    tests++;
    if (m0_gnt !== 1'b0) begin
      fails++;
      $display("FAIL read_latency0: m0_gnt=%b want 0", m0_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bus_addr !== 32'h100 || bus_we !== 1'b0 ||
        m0_rdata !== 32'hCAFE_0001 || m1_rdata !== '0) begin
      fails++;
      $display("FAIL read_grant: gnt0=%b gnt1=%b addr=%h we=%b rd0=%h rd1=%h, want 1 0 100 0 cafe0001 0",
               m0_gnt, m1_gnt, bus_addr, bus_we, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_tie_handover();
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m0_we = 1; m0_wdata = 32'hA0;
    m1_req = 1; m1_addr = 32'h20;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || bus_we !== 1'b1 || bus_wdata !== 32'hA0) begin
      fails++;
      $display("FAIL tie_first: gnt=%b%b we=%b wdata=%h, want 01 1 a0", m1_gnt, m0_gnt, bus_we, bus_wdata);
    end
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    tests++;
    if (m0_gnt !== 1'b1 || bus_we !== 1'b0 || m0_rdata !== '0) begin
      fails++;
      $display("FAIL drop_cycle: gnt0=%b we=%b rd0=%h, want 1 0 0", m0_gnt, bus_we, m0_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || bus_addr !== 32'h20 || m1_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL handover_no_bubble: gnt=%b%b addr=%h rd1=%h, want 10 20 deadbeef",
               m1_gnt, m0_gnt, bus_addr, m1_rdata);
    end
  endtask

  task automatic test_burst_alternate();
    logic [1:0] exp;
    do_reset();
    m0_req = 1; m1_req = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp = (((k / 8) % 2) == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({m1_gnt, m0_gnt} !== exp) begin
        fails++;
        $display("FAIL burst_alternate cycle %0d: gnt=%b%b want %b", k, m1_gnt, m0_gnt, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
        fails++;
        $display("FAIL lock_hold cycle %0d: gnt=%b%b want 01", k, m1_gnt, m0_gnt);
      end
      @(posedge clk); #1;
    end
    m0_lock = 0;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL lock_release_cycle: gnt=%b%b want 01", m1_gnt, m0_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL lock_preempt: gnt=%b%b want 10", m1_gnt, m0_gnt);
    end
  endtask

  task automatic test_write_drop();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (m1_gnt !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h200 || bus_wdata !== 32'h55) begin
      fails++;
      $display("FAIL m1_write: gnt1=%b we=%b addr=%h wdata=%h, want 1 1 200 55", m1_gnt, bus_we, bus_addr, bus_wdata);
    end
    @(posedge clk); #1;
    m1_req = 0;
    @(negedge clk);
    tests++;
    if (m1_gnt !== 1'b1 || bus_we !== 1'b0) begin
      fails++;
      $display("FAIL write_drop_cycle: gnt1=%b we=%b, want 1 0", m1_gnt, bus_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt, bus_we} !== 3'b000 || bus_addr !== '0) begin
      fails++;
      $display("FAIL write_drop_idle: gnt=%b%b we=%b addr=%h, want 00 0 0", m1_gnt, m0_gnt, bus_we, bus_addr);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    m0_req = 1;
    @(posedge clk); #1;
    m1_req = 1;
    @(posedge clk); #1;
    m1_req = 0;
    @(posedge clk); #1;
    m0_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      fails++;
      $display("FAIL withdraw_no_grant: gnt=%b%b want 00", m1_gnt, m0_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      fails++;
      $display("FAIL withdraw_stays_idle: gnt=%b%b want 00", m1_gnt, m0_gnt);
    end
  endtask

  task automatic test_rr_tie();
    do_reset();
    m0_req = 1;
    @(posedge clk); #1;
    m0_req = 0;
    @(posedge clk); #1;
    m0_req = 1; m1_req = 1; m1_addr = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || bus_addr !== 32'h300) begin
      fails++;
      $display("FAIL rr_tie_m1: gnt=%b%b addr=%h, want 10 300", m1_gnt, m0_gnt, bus_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h400; m1_wdata = 32'h77;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (m1_gnt !== 1'b1 || bus_we !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_write: gnt1=%b we=%b, want 1 1", m1_gnt, bus_we);
    end
    #2;
    rst = 0;
    #1;
    tests++;
    if ({m1_gnt, m0_gnt, bus_we} !== 3'b000 || bus_addr !== '0 || bus_wdata !== '0) begin
      fails++;
      $display("FAIL async_reset: gnt=%b%b we=%b addr=%h wdata=%h, want all 0",
               m1_gnt, m0_gnt, bus_we, bus_addr, bus_wdata);
    end
    m0_req = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL post_reset_tie: gnt=%b%b want 01", m1_gnt, m0_gnt);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie_handover();
    test_burst_alternate();
    test_lock();
    test_write_drop();
    test_withdraw();
    test_rr_tie();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
